// File: rtl/operand_bypass_network_if.sv
// ---------------------------------------------------------------------------
// operand_bypass_network_if
//
// Bundles the EX-stage bypass signals between the pipeline control (master)
// and the operand bypass network (slave). Clock and reset stay plain ports
// on the modules.
//
// Signals (direction as seen by the bypass network):
//   i_stall      in   pipeline stall; consumer and producers frozen
//   i_flush      in   flush of the instruction entering EX
//   i_src_reg    in   NUM_SRC x 5    early source indices (next EX instr)
//   i_src_used   in   NUM_SRC        operand j is read by that instruction
//   i_rf_data    in   NUM_SRC x XLEN regfile data, registered at ID->EX
//   i_prod_we    in   NUM_STAGES     producer k writes rd
//   i_prod_rd    in   NUM_STAGES x 5 producer k destination register
//   i_fwd_data   in   NUM_STAGES x XLEN result of producer in stage k
//   i_fwd_ready  in   NUM_STAGES     i_fwd_data[k] is final
//   o_src_value  out  NUM_SRC x XLEN operand value to EX
//   o_fwd_hit    out  NUM_SRC        operand not taken from the regfile
//   o_stall_req  out  1              some operand waits on a not-ready producer
// ---------------------------------------------------------------------------
interface operand_bypass_network_if #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2
);
    logic                                i_stall;
    logic                                i_flush;
    logic [NUM_SRC-1:0][4:0]             i_src_reg;
    logic [NUM_SRC-1:0]                  i_src_used;
    logic [NUM_SRC-1:0][XLEN-1:0]        i_rf_data;
    logic [NUM_STAGES-1:0]               i_prod_we;
    logic [NUM_STAGES-1:0][4:0]          i_prod_rd;
    logic [NUM_STAGES-1:0][XLEN-1:0]     i_fwd_data;
    logic [NUM_STAGES-1:0]               i_fwd_ready;
    logic [NUM_SRC-1:0][XLEN-1:0]        o_src_value;
    logic [NUM_SRC-1:0]                  o_fwd_hit;
    logic                                o_stall_req;

    modport slave (
        input  i_stall, i_flush, i_src_reg, i_src_used, i_rf_data,
               i_prod_we, i_prod_rd, i_fwd_data, i_fwd_ready,
        output o_src_value, o_fwd_hit, o_stall_req
    );

    modport master (
        output i_stall, i_flush, i_src_reg, i_src_used, i_rf_data,
               i_prod_we, i_prod_rd, i_fwd_data, i_fwd_ready,
        input  o_src_value, o_fwd_hit, o_stall_req
    );
endinterface

// File: rtl/operand_bypass_network.sv
// ---------------------------------------------------------------------------
// operand_bypass_network
//
// EX-stage operand bypass for NUM_SRC operands and NUM_STAGES producer
// stages (stage 0 = youngest). The forwarding decision is taken one cycle
// early from the early source indices and registered per operand; EX then
// muxes the live producer data, the regfile data or a hold register.
//
// Per-operand states:
//   ST_RF   : value from regfile (or zero for x0)
//   ST_FWD  : forwarded from stage k, producer not yet seen not-ready
//   ST_WAIT : forwarded from stage k after the producer was seen not-ready
//   ST_HOLD : value frozen in the hold register during a stall
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (same state as a flush)
//   bus      operand_bypass_network_if.slave (see interface file)
//
// Configuration macro FWD_CAPTURE_EN: when defined, a ready ST_FWD operand
// is also captured into the hold register on the first stall cycle, making
// it immune to producer data changes. When undefined, ST_FWD stays live
// during a stall; captures out of ST_WAIT happen in both builds.
// ---------------------------------------------------------------------------
module operand_bypass_network #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    operand_bypass_network_if.slave  bus
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        ST_RF   = 2'd0,
        ST_FWD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } op_state_e;

    logic [NUM_SRC-1:0] stall_vec;

    assign bus.o_stall_req = |stall_vec;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_op
            op_state_e         state_reg, state_next;
            logic [SW-1:0]     stage_reg, stage_next;
            logic              is_x0_reg, is_x0_next;
            logic [XLEN-1:0]   hold_reg, hold_next;
            logic              match;
            logic [SW-1:0]     match_stage;
            logic              sel_ready;
            logic [XLEN-1:0]   sel_data;
            logic [XLEN-1:0]   value;

            assign sel_ready = bus.i_fwd_ready[stage_reg];
            assign sel_data  = bus.i_fwd_data[stage_reg];

            // Priority search: walking from the oldest stage down lets the
            // youngest matching producer overwrite older ones.
            always_comb begin
                match       = 1'b0;
                match_stage = '0;
                for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                    if (bus.i_prod_we[k] && (bus.i_prod_rd[k] != 5'd0) &&
                        (bus.i_prod_rd[k] == bus.i_src_reg[gi])) begin
                        match       = 1'b1;
                        match_stage = SW'(k);
                    end
                end
            end

            always_comb begin
                state_next = state_reg;
                stage_next = stage_reg;
                is_x0_next = is_x0_reg;
                hold_next  = hold_reg;
                if (bus.i_flush) begin
                    state_next = ST_RF;
                    stage_next = '0;
                    is_x0_next = 1'b1;
                    hold_next  = '0;
                end else if (!bus.i_stall) begin
                    // New decision for the instruction entering EX.
                    if (match && bus.i_src_used[gi]) begin
                        state_next = ST_FWD;
                        stage_next = match_stage;
                        is_x0_next = 1'b0;
                    end else begin
                        state_next = ST_RF;
                        stage_next = '0;
                        is_x0_next = (bus.i_src_reg[gi] == 5'd0);
                    end
                end else begin
                    case (state_reg)
                        ST_FWD: begin
                            if (!sel_ready) begin
                                state_next = ST_WAIT;
                            end
`ifdef FWD_CAPTURE_EN
                            else begin
                                state_next = ST_HOLD;
                                hold_next  = sel_data;
                            end
`endif
                        end
                        ST_WAIT: begin
                            if (sel_ready) begin
                                state_next = ST_HOLD;
                                hold_next  = sel_data;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    state_reg <= ST_RF;
                    stage_reg <= '0;
                    is_x0_reg <= 1'b1;
                    hold_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    stage_reg <= stage_next;
                    is_x0_reg <= is_x0_next;
                    hold_reg  <= hold_next;
                end
            end

            // A not-ready forward shows the hold register; its content is
            // meaningless there, but o_stall_req holds EX back meanwhile.
            always_comb begin
                value = hold_reg;
                case (state_reg)
                    ST_RF:          value = is_x0_reg ? '0 : bus.i_rf_data[gi];
                    ST_FWD, ST_WAIT: if (sel_ready) value = sel_data;
                    default:        value = hold_reg;
                endcase
            end

            assign bus.o_src_value[gi] = value;
            assign bus.o_fwd_hit[gi]   = (state_reg != ST_RF);
            assign stall_vec[gi]       = ((state_reg == ST_FWD) || (state_reg == ST_WAIT))
                                         && !sel_ready;
        end
    endgenerate
endmodule
